// File: rtl/db9_pad_scanner.sv
// db9_pad_scanner
//   Scans up to two DB9 game pads through one shared set of pins. Each frame
//   holds the select line high for an idle period (long enough for 6-button
//   pads to reset their internal select counter), then clocks eight select
//   phases for player 1 and eight for player 2. Pad pins are sampled on the
//   last clock of each phase; the decoded 16-bit word and the detection flags
//   for a player are published atomically once that player's phase 7 ends.
//
// Parameters
//   STEP_CYCLES : clocks per select phase
//   IDLE_STEPS  : phases held idle between scan frames
//
// Ports
//   clk       : in  system clock
//   reset     : in  asynchronous, active-high reset
//   joy_in    : in  [5:0] pad pins, active-low {TR, TL, Up, Down, Left, Right}
//   joy_mdsel : out pad select line (registered)
//   joy_split : out port mux select, 0 = player 1, 1 = player 2 (registered)
//   joystick1 : out [15:0] player 1 buttons, active-high
//   joystick2 : out [15:0] player 2 buttons, active-high
//   present   : out [1:0] Mega Drive pad detected, per player
//   six_btn   : out [1:0] 6-button pad detected, per player
//
// Button word: [0] R [1] L [2] D [3] U [4] B [5] C [6] A [7] Start
//              [8] Mode [9] X [10] Y [11] Z, [15:12] always zero.

module db9_pad_scanner #(
  parameter int STEP_CYCLES = 240,
  parameter int IDLE_STEPS  = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  present,
  output logic [1:0]  six_btn
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int IW = (IDLE_STEPS > 0) ? $clog2(IDLE_STEPS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cyc, cyc_nxt;
  logic [2:0]      phase, phase_nxt;
  logic [IW-1:0]   idle_cnt, idle_nxt;
  logic            mdsel_nxt, split_nxt;
  logic            phase_end;

  // Per-phase samples, stored active-high. Every one of them is rewritten
  // before the phase 7 publish of each player, so they need no reset.
  logic [5:0]      samp_p0;
  logic [5:0]      samp_p1;
  logic            six_p5;
  logic [3:0]      samp_p6;
  logic [17:0]     frame_word;

  // Decode the captured phases into {six, present, word}. A pad that never
  // pulled Left+Right low in phase 1 is a plain DB9 stick: only the phase 0
  // directions and the two fire buttons are meaningful.
  function automatic logic [17:0] pack_frame(
    input logic [5:0] s0,
    input logic [5:0] s1,
    input logic       s5,
    input logic [3:0] s6
  );
    logic        pres;
    logic        six;
    logic [15:0] word;
    pres = s1[0] & s1[1];
    six  = pres & s5;
    word = 16'h0000;
    word[5:0] = s0;                    // C, B, U, D, L, R
    if (pres) begin
      word[6] = s1[4];                 // A on TL
      word[7] = s1[5];                 // Start on TR
    end
    if (six) begin
      word[11:8] = s6;                 // Z=U, Y=D, X=L, Mode=R
    end
    return {six, pres, word};
  endfunction

  assign phase_end  = (cyc == CW'(STEP_CYCLES - 1));
  assign frame_word = pack_frame(samp_p0, samp_p1, six_p5, samp_p6);

  // Sequencer: phase timing, state transitions and next select-line values.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    phase_nxt = phase;
    idle_nxt  = idle_cnt;
    if (!phase_end) begin
      cyc_nxt = cyc + 1'b1;
    end else begin
      cyc_nxt = '0;
      case (state)
        IDLE: begin
          if (idle_cnt == IW'(IDLE_STEPS - 1)) begin
            state_nxt = P1;
            idle_nxt  = '0;
            phase_nxt = 3'd0;
          end else begin
            idle_nxt = idle_cnt + 1'b1;
          end
        end
        P1: begin
          if (phase == 3'd7) begin
            state_nxt = P2;
            phase_nxt = 3'd0;
          end else begin
            phase_nxt = phase + 3'd1;
          end
        end
        P2: begin
          if (phase == 3'd7) begin
            state_nxt = IDLE;
            phase_nxt = 3'd0;
          end else begin
            phase_nxt = phase + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          phase_nxt = 3'd0;
          idle_nxt  = '0;
        end
      endcase
    end

    // Select is high through idle and on even phases of a player slot.
    mdsel_nxt = (state_nxt == IDLE) || !phase_nxt[0];

    // The port mux only moves when a player slot begins.
    split_nxt = joy_split;
    if (state_nxt == P1 && state != P1) split_nxt = 1'b0;
    if (state_nxt == P2 && state != P2) split_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      phase     <= 3'd0;
      idle_cnt  <= '0;
      joy_mdsel <= 1'b1;
      joy_split <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      phase     <= phase_nxt;
      idle_cnt  <= idle_nxt;
      joy_mdsel <= mdsel_nxt;
      joy_split <= split_nxt;
    end
  end

  // Phase sampling: pins are read on the last clock of the phase only, the
  // earlier clocks give the pad time to respond to the select change.
  always_ff @(posedge clk) begin
    if (state != IDLE && phase_end) begin
      case (phase)
        3'd0:    samp_p0 <= ~joy_in;
        3'd1:    samp_p1 <= ~joy_in;
        3'd5:    six_p5  <= &(~joy_in[3:0]);
        3'd6:    samp_p6 <= ~joy_in[3:0];
        default: ;
      endcase
    end
  end

  // Publish stage: one player's word and flags move together at the end of
  // its phase 7, so readers never see a partially scanned frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joystick1 <= 16'h0000;
      joystick2 <= 16'h0000;
      present   <= 2'b00;
      six_btn   <= 2'b00;
    end else if (phase_end && phase == 3'd7) begin
      if (state == P1) begin
        joystick1  <= frame_word[15:0];
        present[0] <= frame_word[16];
        six_btn[0] <= frame_word[17];
      end else if (state == P2) begin
        joystick2  <= frame_word[15:0];
        present[1] <= frame_word[16];
        six_btn[1] <= frame_word[17];
      end
    end
  end

endmodule

// File: tb/tb_db9_pad_scanner.sv
// Testbench for db9_pad_scanner with STEP_CYCLES=4, IDLE_STEPS=2 (72-clock
// frames). Behavioural pad models (none, DB9 stick, 3-button and 6-button
// Mega Drive pads) answer the select line by counting its edges. Expected
// words are queued per player when a frame's pad configuration is applied
// and popped at that player's publish clock.

module tb_db9_pad_scanner;

  localparam int SC    = 4;
  localparam int IS    = 2;
  localparam int FRAME = (16 + IS) * SC;
  localparam int IDLEC = IS * SC;
  localparam int P2C   = IDLEC + 8 * SC;

  localparam int T_NONE = 0;
  localparam int T_DB9  = 1;
  localparam int T_MD3  = 2;
  localparam int T_MD6  = 3;

  logic        clk;
  logic        reset;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  present;
  logic [1:0]  six_btn;

  db9_pad_scanner #(
    .STEP_CYCLES(SC),
    .IDLE_STEPS (IS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .joy_in   (joy_in),
    .joy_mdsel(joy_mdsel),
    .joy_split(joy_split),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .present  (present),
    .six_btn  (six_btn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Pad configurations, button sets in the joystick bit map.
  int          t1, t2;
  logic [11:0] b1, b2;

  // Pad-side select phase tracker.
  int   pcnt;
  int   hi_run;
  logic prev_md;
  logic prev_split;

  // {six, present, word} in the joystick bit map.
  function automatic logic [17:0] expect_of(input int t, input logic [11:0] b);
    case (t)
      T_DB9:   return {2'b00, 4'h0, b & 12'h03F};
      T_MD3:   return {2'b01, 4'h0, b & 12'h0FF};
      T_MD6:   return {2'b11, 4'h0, b};
      default: return 18'h0;
    endcase
  endfunction

  // Pins driven by a pad, active-low {TR, TL, U, D, L, R}.
  function automatic logic [5:0] pad_out(input int t, input logic [11:0] b, input int ph);
    logic [5:0] p;
    logic r, l, d, u, bb, c, a, st, mo, x, y, z;
    {z, y, x, mo, st, a, c, bb, u, d, l, r} = {b[11], b[10], b[9], b[8], b[7], b[6],
                                               b[5], b[4], b[3], b[2], b[1], b[0]};
    p = 6'b0;
    case (t)
      T_DB9: p = {c, bb, u, d, l, r};
      T_MD3, T_MD6: begin
        if (t == T_MD6 && ph == 6)      p = {c, bb, z, y, x, mo};
        else if (t == T_MD6 && ph == 5) p = {st, a, 4'b1111};
        else if (t == T_MD6 && ph == 7) p = {st, a, 4'b0000};
        else if (ph % 2 == 1)           p = {st, a, u, d, 2'b11};
        else                            p = {c, bb, u, d, l, r};
      end
      default: p = 6'b0;
    endcase
    return ~p;
  endfunction

  assign joy_in = joy_split ? pad_out(t2, b2, pcnt) : pad_out(t1, b1, pcnt);

  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [17:0] held1, held2;
  logic        split_idle;

  // Checks for one clock of a frame, then advances the pad tracker.
  task automatic cycle_checks(input int fr, input int c);
    logic exp_md;
    logic exp_split;
    exp_md = (c < IDLEC) ? 1'b1 : ~((((c - IDLEC) / SC) % 2) == 1);
    if (c < IDLEC)    exp_split = split_idle;
    else if (c < P2C) exp_split = 1'b0;
    else              exp_split = 1'b1;
    chk("mdsel", {31'b0, joy_mdsel}, {31'b0, exp_md});
    chk("split", {31'b0, joy_split}, {31'b0, exp_split});

    if (c == P2C) begin
      if (q1.size() == 0) chk("sb1_empty", 32'd0, 32'd1);
      else held1 = q1.pop_front();
      split_idle = 1'b1;
    end
    if (c == 0 && fr > 0) begin
      if (q2.size() == 0) chk("sb2_empty", 32'd0, 32'd1);
      else held2 = q2.pop_front();
    end
    chk("joystick1", {16'b0, joystick1}, {16'b0, held1[15:0]});
    chk("present0",  {31'b0, present[0]}, {31'b0, held1[16]});
    chk("six0",      {31'b0, six_btn[0]}, {31'b0, held1[17]});
    chk("joystick2", {16'b0, joystick2}, {16'b0, held2[15:0]});
    chk("present1",  {31'b0, present[1]}, {31'b0, held2[16]});
    chk("six1",      {31'b0, six_btn[1]}, {31'b0, held2[17]});

    hi_run = joy_mdsel ? hi_run + 1 : 0;
    if (joy_split != prev_split)  pcnt = 0;
    else if (joy_mdsel != prev_md) pcnt = pcnt + 1;
    else if (hi_run > SC)          pcnt = 0;
    prev_md    = joy_mdsel;
    prev_split = joy_split;
  endtask

  // One frame: apply pad configuration, queue expectations, run its clocks.
  // mid_b1 >= 0 swaps player 1's buttons during P1 phase 3; stop_c ends early.
  task automatic run_frame(input int fr, input int nt1, input int nb1,
                           input int nt2, input int nb2,
                           input int mid_b1, input int stop_c);
    t1 = nt1; b1 = nb1[11:0];
    t2 = nt2; b2 = nb2[11:0];
    q1.push_back(expect_of(nt1, nb1[11:0]));
    q2.push_back(expect_of(nt2, nb2[11:0]));
    for (int c = 0; c < FRAME; c++) begin
      if (c == stop_c) return;
      if (c == IDLEC + 3 * SC && mid_b1 >= 0) b1 = mid_b1[11:0];
      cycle_checks(fr, c);
      @(negedge clk);
    end
  endtask

  task automatic reset_model();
    q1.delete();
    q2.delete();
    held1      = 18'h0;
    held2      = 18'h0;
    split_idle = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    t1 = T_NONE; t2 = T_NONE; b1 = 12'h0; b2 = 12'h0;
    pcnt = 0; hi_run = 0; prev_md = 1'b1; prev_split = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_joy1",  {16'b0, joystick1}, 32'h0);
    chk("rst_joy2",  {16'b0, joystick2}, 32'h0);
    chk("rst_pres",  {30'b0, present},   32'h0);
    chk("rst_six",   {30'b0, six_btn},   32'h0);
    chk("rst_mdsel", {31'b0, joy_mdsel}, 32'h1);
    chk("rst_split", {31'b0, joy_split}, 32'h0);
    reset = 1'b0;

    run_frame(0, T_MD3,  'h048, T_MD6,  'h980, -1, FRAME);   // Up+A / Start+Z+Mode
    run_frame(1, T_NONE, 'h000, T_MD6,  'h641, -1, FRAME);   // unplugged / A+X+Y+R
    run_frame(2, T_DB9,  'h001, T_MD3,  'h134, -1, FRAME);   // Right / D+B+C (+Mode)
    run_frame(3, T_DB9,  'h078, T_NONE, 'h000, -1, FRAME);   // U+B+C (+A)
    run_frame(4, T_MD3,  'h08B, T_MD6,  'hFFF, -1, FRAME);   // L+R+U+Start / all
    run_frame(5, T_MD3,  'h010, T_MD6,  'h080, 'h028, FRAME); // change mid-scan
    run_frame(6, T_MD3,  'h028, T_MD6,  'h080, -1, FRAME);
    run_frame(7, T_MD3,  'h001, T_MD6,  'h100, -1, P2C + 3 * SC);

    // Reset in the middle of P2 phase 3.
    reset = 1'b1;
    #1;
    chk("mid_joy1",  {16'b0, joystick1}, 32'h0);
    chk("mid_joy2",  {16'b0, joystick2}, 32'h0);
    chk("mid_pres",  {30'b0, present},   32'h0);
    chk("mid_six",   {30'b0, six_btn},   32'h0);
    chk("mid_mdsel", {31'b0, joy_mdsel}, 32'h1);
    chk("mid_split", {31'b0, joy_split}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    reset_model();

    run_frame(0, T_MD6,  'h210, T_DB9,  'h002, -1, FRAME);   // B+X / Left
    run_frame(1, T_MD3,  'h210, T_MD3,  'h0C0, -1, FRAME);   // X dropped / A+Start
    run_frame(2, T_NONE, 'h000, T_NONE, 'h000, -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
